cpu_phase_ctrl: RTL and testbench

Four-phase timing and register-address controller for the multi-cycle CPU. It sits directly upstream of the register file. It fetches each instruction over a req/ack handshake and holds it in an instruction register. It steps one-hot T1–T4 phase strobes, inserting a memory wait phase for loads and stores, and decodes the held instruction into the register file's read addresses, write address and write enable. The register file commits on `T3 & we`; this block guarantees T3 is a single-cycle pulse per instruction.

---
 rtl/cpu_phase_pkg.sv | 25 ++
 rtl/cpu_phase_decode.sv | 47 ++++
 rtl/cpu_phase_ctrl.sv | 110 +++++++++++
 tb/tb_cpu_phase_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_phase_pkg.sv
// Shared phase-controller types: FSM states and the opcode/funct constants the decoder keys on.
package cpu_phase_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3W  = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_ITYPE_LO = 6'h08;
  localparam logic [5:0] OP_ITYPE_HI = 6'h0F;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SW       = 6'h2B;
  localparam logic [5:0] FUNCT_JR    = 6'h08;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/cpu_phase_decode.sv
// Combinational ir -> register file addresses/write enable, plus the load/store flag for S_T2.
// Zero latency; no handshake.
module cpu_phase_decode
  import cpu_phase_pkg::*;
#(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic [31:0] ir,
  output logic [4:0]  raddr1,
  output logic [4:0]  raddr2,
  output logic [4:0]  waddr,
  output logic        we,
  output logic        mem_op
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       writer;
  logic       unused_shamt;

  assign op           = ir[31:26];
  assign funct        = ir[5:0];
  assign raddr1       = ir[25:21];
  assign raddr2       = ir[20:16];
  assign mem_op       = is_mem_op(op);
  assign unused_shamt = ^ir[10:6];

  always_comb begin
    writer = 1'b0;
    waddr  = ir[20:16];
    if (op == OP_RTYPE) begin
      waddr  = ir[15:11];
      writer = (funct != FUNCT_JR);
    end else if (op == OP_JAL) begin
      waddr  = LINK_REG;
      writer = 1'b1;
    end else if ((op >= OP_ITYPE_LO) && (op <= OP_ITYPE_HI)) begin
      writer = 1'b1;
    end else if (op == OP_LW) begin
      writer = 1'b1;
    end
  end

  // Writes to r0 are suppressed here so the register file never sees them.
  assign we = writer && (waddr != 5'd0);

endmodule

// File: rtl/cpu_phase_ctrl.sv
// Four-phase T1-T4 sequencer with instruction register and regfile address decode; optional CPU_PHASE_INSTRET_EN adds a retired-instruction counter.
// 4 cycles per instruction, +1 for load/store plus one per data wait cycle; stalls in T1 on inst_ack and in S_T3W on data_ack.
module cpu_phase_ctrl
  import cpu_phase_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [4:0]  LINK_REG = 5'd31
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic        data_req,
  input  logic        data_ack,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        T1,
  output logic        T2,
  output logic        T3,
  output logic        T4,
  output logic [4:0]  raddr1,
  output logic [4:0]  raddr2,
  output logic [4:0]  waddr,
  output logic        we
`ifdef CPU_PHASE_INSTRET_EN
  ,
  output logic [31:0] instret
`endif
);

  state_t state_q;
  state_t state_d;
  logic   mem_op;

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    inst_req = 1'b0;
    data_req = 1'b0;
    T1       = 1'b0;
    T2       = 1'b0;
    T3       = 1'b0;
    T4       = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_T1;
      S_T1: begin
        inst_req = 1'b1;
        T1       = 1'b1;
        if (inst_ack) state_d = S_T2;
      end
      S_T2: begin
        T2      = 1'b1;
        state_d = mem_op ? S_T3W : S_T3;
      end
      S_T3W: begin
        data_req = 1'b1;
        if (data_ack) state_d = S_T3;
      end
      // Always a single cycle: the register file commits on T3 & we.
      S_T3: begin
        T3      = 1'b1;
        state_d = S_T4;
      end
      S_T4: begin
        T4      = 1'b1;
        state_d = S_T1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc <= RESET_PC;
      ir <= '0;
    end else begin
      if ((state_q == S_T1) && inst_ack) ir <= inst_rdata;
      if (state_q == S_T4)               pc <= pc_next;
    end
  end

`ifdef CPU_PHASE_INSTRET_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (!resetn)                 instret_q <= '0;
    else if (state_q == S_T4)    instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`endif

  cpu_phase_decode #(
    .LINK_REG (LINK_REG)
  ) u_decode (
    .ir     (ir),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .waddr  (waddr),
    .we     (we),
    .mem_op (mem_op)
  );

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Bench for cpu_phase_ctrl: per-instruction expectations queued at fetch, popped and checked at T4.
module tb_cpu_phase_ctrl;
  import cpu_phase_pkg::*;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_ack;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        T1, T2, T3, T4;
  logic [4:0]  raddr1, raddr2, waddr;
  logic        we;
`ifdef CPU_PHASE_INSTRET_EN
  logic [31:0] instret;
  logic [31:0] exp_instret;
`endif

  typedef struct {
    logic [31:0] ir;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [4:0]  waddr;
    logic        we;
    int          cycles;
    logic [31:0] pc_after;
  } exp_t;

  exp_t        sbq[$];
  int          ncmp;
  int          nfail;
  logic [31:0] exp_pc;

  cpu_phase_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .inst_req   (inst_req),
    .inst_ack   (inst_ack),
    .inst_rdata (inst_rdata),
    .data_req   (data_req),
    .data_ack   (data_ack),
    .pc_next    (pc_next),
    .pc         (pc),
    .ir         (ir),
    .T1         (T1),
    .T2         (T2),
    .T3         (T3),
    .T4         (T4),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .waddr      (waddr),
    .we         (we)
`ifdef CPU_PHASE_INSTRET_EN
    ,
    .instret    (instret)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required finish)", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting from its T1 cycle. inst_ack/data_ack are held high
  // outside their own phases, with junk data, so stray acks would be noticed.
  task automatic run_instr(input string nm, input logic [31:0] instr, input int iwait,
                           input int dwait, input logic [31:0] nxt,
                           input logic [4:0] ewaddr, input logic ewe, input int ecyc);
    exp_t        e;
    exp_t        got;
    int          cyc, t1c, t2c, t3c, t4c, dc;
    bit          done;
    logic [31:0] ir_prev;
    e.ir       = instr;
    e.raddr1   = instr[25:21];
    e.raddr2   = instr[20:16];
    e.waddr    = ewaddr;
    e.we       = ewe;
    e.cycles   = ecyc;
    e.pc_after = nxt;
    sbq.push_back(e);
    cyc = 0; t1c = 0; t2c = 0; t3c = 0; t4c = 0; dc = 0; done = 0;
    ir_prev = ir;
    for (int k = 0; k < 64 && !done; k++) begin
      cyc++;
      inst_ack   = 1'b1;
      inst_rdata = 32'hDEAD_BEEF;
      data_ack   = 1'b1;
      pc_next    = 32'hBAD0_0000;
      ncmp++;
      if ($countones({T1, T2, T3, T4}) > 1) begin
        nfail++; $display("FAIL %s onehot: strobes=%b required at most one high", nm, {T1, T2, T3, T4});
      end
      if (T1) begin
        t1c++;
        ncmp++;
        if (pc !== exp_pc) begin
          nfail++; $display("FAIL %s pc_t1: got %h required %h", nm, pc, exp_pc);
        end
        if (t1c > iwait) inst_rdata = instr;
        else begin
          inst_ack = 1'b0;
          ncmp++;
          if (ir !== ir_prev) begin
            nfail++; $display("FAIL %s ir_hold: got %h required %h", nm, ir, ir_prev);
          end
        end
      end
      if (data_req) begin
        dc++;
        data_ack = (dc > dwait);
      end
      if (T2) t2c++;
      if (T3) t3c++;
      if (T2 || T3 || T4) begin
        ncmp++;
        if ({ir, raddr1, raddr2, waddr, we} !== {sbq[0].ir, sbq[0].raddr1, sbq[0].raddr2, sbq[0].waddr, sbq[0].we}) begin
          nfail++;
          $display("FAIL %s decode: got ir=%h r1=%0d r2=%0d wa=%0d we=%b required ir=%h r1=%0d r2=%0d wa=%0d we=%b",
                   nm, ir, raddr1, raddr2, waddr, we,
                   sbq[0].ir, sbq[0].raddr1, sbq[0].raddr2, sbq[0].waddr, sbq[0].we);
        end
      end
      if (T4) begin
        t4c++;
        pc_next = nxt;
        done    = 1;
      end
      tick();
    end
    if (!done) begin
      nfail++; ncmp++;
      $display("FAIL %s timeout: no T4 within 64 cycles, required T4", nm);
      void'(sbq.pop_front());
      return;
    end
    got = sbq.pop_front();
    ncmp++;
    if (cyc !== got.cycles) begin
      nfail++; $display("FAIL %s cycles: got %0d required %0d", nm, cyc, got.cycles);
    end
    ncmp++;
    if (pc !== got.pc_after) begin
      nfail++; $display("FAIL %s pc_after: got %h required %h", nm, pc, got.pc_after);
    end
    ncmp++;
    if ({t2c, t3c, t4c} !== {32'd1, 32'd1, 32'd1}) begin
      nfail++; $display("FAIL %s strobe_counts: got T2=%0d T3=%0d T4=%0d required 1 each", nm, t2c, t3c, t4c);
    end
    ncmp++;
    if (dc !== got.cycles - 4 - iwait) begin
      nfail++; $display("FAIL %s data_req_cycles: got %0d required %0d", nm, dc, got.cycles - 4 - iwait);
    end
    ncmp++;
    if (T1 !== 1'b1) begin
      nfail++; $display("FAIL %s next_t1: got T1=%b required 1", nm, T1);
    end
    exp_pc = nxt;
`ifdef CPU_PHASE_INSTRET_EN
    exp_instret = exp_instret + 32'd1;
    ncmp++;
    if (instret !== exp_instret) begin
      nfail++; $display("FAIL %s instret: got %h required %h", nm, instret, exp_instret);
    end
`endif
  endtask

  task automatic test_reset();
    resetn = 1'b0; inst_ack = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    data_ack = 1'b1; pc_next = 32'h1234_5678;
    repeat (3) tick();
    ncmp++;
    if ({inst_req, data_req, T1, T2, T3, T4} !== 6'b0 || pc !== 32'h0 || ir !== 32'h0) begin
      nfail++; $display("FAIL reset_values: req=%b dreq=%b T=%b pc=%h ir=%h required all zero",
                        inst_req, data_req, {T1, T2, T3, T4}, pc, ir);
    end
    ncmp++;
    if (dut.state_q !== S_IDLE) begin
      nfail++; $display("FAIL reset_state: got %0d required S_IDLE", dut.state_q);
    end
`ifdef CPU_PHASE_INSTRET_EN
    exp_instret = 32'h0;
    ncmp++;
    if (instret !== 32'h0) begin
      nfail++; $display("FAIL reset_instret: got %h required 0", instret);
    end
`endif
    resetn = 1'b1;
    ncmp++;
    if (inst_req !== 1'b0) begin
      nfail++; $display("FAIL idle_cycle: inst_req got %b required 0", inst_req);
    end
    tick();
    ncmp++;
    if (inst_req !== 1'b1 || T1 !== 1'b1) begin
      nfail++; $display("FAIL first_req: inst_req=%b T1=%b required 1 1", inst_req, T1);
    end
    exp_pc = 32'h0;
    run_instr("reset_nop", 32'h0000_0000, 0, 0, 32'h0000_0004, 5'd0, 1'b0, 4);
  endtask

  task automatic test_decode();
    run_instr("addu",      32'h012A_4021, 0, 0, 32'h0000_0008, 5'd8,  1'b1, 4);
    run_instr("jal",       32'h0C00_0010, 0, 0, 32'h0000_0040, 5'd31, 1'b1, 4);
    run_instr("jr",        32'h03E0_0008, 0, 0, 32'h0000_0044, 5'd0,  1'b0, 4);
    run_instr("addiu_r0",  32'h2400_0005, 0, 0, 32'h0000_0048, 5'd0,  1'b0, 4);
    run_instr("addiu_r5",  32'h2405_0007, 0, 0, 32'h0000_004C, 5'd5,  1'b1, 4);
    run_instr("ori_r3",    32'h3403_00FF, 0, 0, 32'h0000_0050, 5'd3,  1'b1, 4);
    run_instr("beq",       32'h1109_0003, 0, 0, 32'h0000_0060, 5'd9,  1'b0, 4);
    run_instr("fetch_wait", 32'h012A_4021, 2, 0, 32'h0000_0064, 5'd8, 1'b1, 6);
  endtask

  task automatic test_memory();
    run_instr("lw_wait3", 32'h8D09_0004, 0, 3, 32'h0000_0068, 5'd9, 1'b1, 8);
    run_instr("sw_ack0",  32'hAD09_0004, 0, 0, 32'h0000_006C, 5'd9, 1'b0, 5);
    run_instr("lw_ack0",  32'h8D0A_0008, 0, 0, 32'h0000_0070, 5'd10, 1'b1, 5);
  endtask

  task automatic test_reset_abort();
    bit saw_t3;
    saw_t3 = 0;
    inst_ack = 1'b1; inst_rdata = 32'h8D09_0004; data_ack = 1'b0;
    tick();
    if (T3) saw_t3 = 1;
    tick();
    ncmp++;
    if (data_req !== 1'b1) begin
      nfail++; $display("FAIL abort_setup: data_req got %b required 1", data_req);
    end
`ifdef CPU_PHASE_INSTRET_EN
    ncmp++;
    if (instret !== exp_instret) begin
      nfail++; $display("FAIL abort_instret_hold: got %h required %h", instret, exp_instret);
    end
`endif
    resetn = 1'b0; data_ack = 1'b1; pc_next = 32'hFFFF_FFF0;
    tick();
    if (T3) saw_t3 = 1;
    ncmp++;
    if (dut.state_q !== S_IDLE || data_req !== 1'b0 || saw_t3 || pc !== 32'h0) begin
      nfail++; $display("FAIL abort: state=%0d data_req=%b t3_seen=%b pc=%h required S_IDLE 0 0 00000000",
                        dut.state_q, data_req, saw_t3, pc);
    end
`ifdef CPU_PHASE_INSTRET_EN
    exp_instret = 32'h0;
    ncmp++;
    if (instret !== 32'h0) begin
      nfail++; $display("FAIL abort_instret_clear: got %h required 0", instret);
    end
`endif
    resetn = 1'b1;
    tick();
    exp_pc = 32'h0;
    run_instr("post_abort", 32'h012A_4021, 0, 0, 32'h0000_0004, 5'd8, 1'b1, 4);
  endtask

`ifdef CPU_PHASE_INSTRET_EN
  task automatic test_instret_wrap();
    force dut.instret_q = 32'hFFFF_FFFE;
    #1;
    release dut.instret_q;
    exp_instret = 32'hFFFF_FFFE;
    run_instr("wrap0", 32'h2405_0001, 0, 0, 32'h0000_0008, 5'd5, 1'b1, 4);
    run_instr("wrap1", 32'h2405_0002, 0, 0, 32'h0000_000C, 5'd5, 1'b1, 4);
    run_instr("wrap2", 32'h2405_0003, 0, 0, 32'h0000_0010, 5'd5, 1'b1, 4);
    ncmp++;
    if (instret !== 32'h1) begin
      nfail++; $display("FAIL instret_wrap_final: got %h required 00000001", instret);
    end
  endtask
`endif

  initial begin
    ncmp = 0; nfail = 0; exp_pc = 32'h0;
    resetn = 1'b0; inst_ack = 1'b0; inst_rdata = 32'h0; data_ack = 1'b0; pc_next = 32'h0;
    test_reset();
    test_decode();
    test_memory();
    test_reset_abort();
`ifdef CPU_PHASE_INSTRET_EN
    test_instret_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
